cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Upstream stage of the directory. It owns the 22-bit common data bus (CDB) that the directory samples each clock.
- Collects messages from the two processor cache controllers (PC0, PC1) and the directory's own emit path, buffers each source in a small FIFO, and drives exactly one message per cycle onto the CDB.
- Directory responses have absolute priority. PC0/PC1 requests alternate round-robin.
- Idle encoding on every 22-bit message path is all ones (22'h3FFFFF).

Parameters:
- DEPTH, 4, entries per source FIFO (power of two, 2..16)
- IDLE, 22'h3FFFFF, no-message encoding on inputs and CDB

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- pc0_msg  input  22  message from PC0; IDLE = nothing offered
- pc1_msg  input  22  message from PC1; IDLE = nothing offered
- dir_msg  input  22  directory emit; IDLE = nothing offered
- cdb  output  22  registered bus value consumed by directory and both PCs
- grant  output  2  registered source of current cdb: 0 none, 1 PC0, 2 PC1, 3 DIR
- pc0_full  output  1  PC0 FIFO count == DEPTH (combinational from count)
- pc1_full  output  1  PC1 FIFO count == DEPTH
- dir_full  output  1  DIR FIFO count == DEPTH
- overflow  output  3  sticky drop flags {dir, pc1, pc0}

Behaviour:
- Message layout (not interpreted by this block):
  - [21:16] opcode
  - [15:13] tag
  - [12] processor id
  - [11:0] data
  - Contents pass through bit-exact.
- Reset (synchronous, takes effect at the rising edge where reset=1):
  - All FIFOs emptied.
  - cdb=IDLE, grant=0, overflow=3'b000, all full flags 0.
  - Round-robin pointer set to PC0-first.
  - Reset mid-operation discards all queued messages; no partial message appears on cdb afterwards.
- Enqueue, per source, each rising edge:
  - A message is pushed if input != IDLE and (count < DEPTH or that FIFO is popped in the same cycle).
  - Otherwise the message is dropped and the corresponding overflow bit is set. Overflow bits clear only on reset.
  - An IDLE input never pushes.
- Issue, each rising edge, using FIFO heads as they stood before this edge's pushes:
  - If DIR FIFO is non-empty: pop it, cdb <= head, grant <= 3.
  - Else if both PC FIFOs are non-empty: pop the one the pointer selects, then flip the pointer to the other PC.
  - Else if exactly one PC FIFO is non-empty: pop it, and point the pointer at the other PC.
  - Else: cdb <= IDLE, grant <= 0.
  - The pointer changes only on a PC grant.
- Latency:
  - A message sampled at edge k is eligible at edge k+1. No input-to-cdb bypass.
  - With empty queues, the message appears on cdb after edge k+1 and stays exactly one cycle.
- cdb holds a granted message for one cycle only. If nothing is granted at the next edge it returns to IDLE, so the directory never sees a repeated message.
- FIFO order within a source is strict first-in, first-out. Read and write pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Simultaneous push and pop on a full FIFO: both occur, count stays DEPTH, no overflow.
- Starvation bound:
  - A PC head waits at most one competing PC grant, plus any run of DIR grants.
  - DIR traffic is bounded in practice because the directory emits at most one response per CDB message.

Test Plan:
- Reset, then all inputs IDLE for 5 cycles -> cdb=22'h3FFFFF, grant=0, overflow=0, full flags 0 throughout.
- pc0_msg=22'h012000 for one cycle at edge k -> cdb=22'h012000 and grant=1 after edge k+1 only; cdb=IDLE after edge k+2.
- pc0_msg=22'h012000, pc1_msg=22'h013000 and dir_msg=22'h042000 offered in the same cycle -> cdb sequence 22'h042000 (grant 3), 22'h012000 (grant 1), 22'h013000 (grant 2).
- PC0 and PC1 each offer 3 messages back-to-back while DIR is idle -> grants alternate 1,2,1,2,1,2 and per-source order is preserved.
- pc1_msg held non-IDLE for DEPTH+2 cycles while DIR is kept busy so PC1 is never granted -> pc1_full=1 after DEPTH pushes, overflow[1]=1, and the dropped messages never appear on cdb.
- Assert reset with 3 messages queued and one on cdb -> cdb=IDLE, grant=0 and FIFOs empty after the reset edge, and no queued message appears afterwards.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers messages from PC0, PC1 and the directory emit path in
// per-source FIFOs and drives one message per cycle onto the registered CDB.
// Directory traffic always wins; PC0/PC1 share the remaining slots round-robin.
module cdb_arbiter #(
    parameter int          DEPTH = 4,
    parameter logic [21:0] IDLE  = 22'h3FFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [21:0] pc0_msg,
    input  logic [21:0] pc1_msg,
    input  logic [21:0] dir_msg,
    output logic [21:0] cdb,
    output logic [1:0]  grant,
    output logic        pc0_full,
    output logic        pc1_full,
    output logic        dir_full,
    output logic [2:0]  overflow
);

    localparam int NSRC = 3;                 // 0 = PC0, 1 = PC1, 2 = DIR
    localparam int AW   = $clog2(DEPTH);     // pointer width, wraps modulo DEPTH
    localparam int CW   = AW + 1;            // occupancy needs to reach DEPTH
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_PC0  = 2'd1;
    localparam logic [1:0] GRANT_PC1  = 2'd2;
    localparam logic [1:0] GRANT_DIR  = 2'd3;

    logic [21:0]     in_msg [NSRC];
    logic [21:0]     head   [NSRC];
    logic [NSRC-1:0] empty;
    logic [NSRC-1:0] full;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] drop;
    logic [NSRC-1:0] pop;

    logic [21:0] cdb_reg,   cdb_next;
    logic [1:0]  grant_reg, grant_next;
    logic        rr_reg,    rr_next;        // 0: PC0 goes first on a tie, 1: PC1
    logic [2:0]  overflow_reg;

    assign in_msg[0] = pc0_msg;
    assign in_msg[1] = pc1_msg;
    assign in_msg[2] = dir_msg;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_fifo
            logic [21:0]   mem_reg [DEPTH];
            logic [AW-1:0] rd_ptr_reg;
            logic [AW-1:0] wr_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          offered;

            assign offered   = (in_msg[gi] != IDLE);
            assign empty[gi] = (count_reg == '0);
            assign full[gi]  = (count_reg == FULL_COUNT);
            // A full FIFO still accepts a message when its head leaves this cycle.
            assign push[gi]  = offered && (!full[gi] || pop[gi]);
            assign drop[gi]  = offered && full[gi] && !pop[gi];
            assign head[gi]  = mem_reg[rd_ptr_reg];

            // Message storage; contents are don't-care until count covers them.
            always_ff @(posedge clock) begin
                if (push[gi]) begin
                    mem_reg[wr_ptr_reg] <= in_msg[gi];
                end
            end

            // Read/write pointers and occupancy count.
            always_ff @(posedge clock) begin
                if (reset) begin
                    rd_ptr_reg <= '0;
                    wr_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + CW'(1);
                        2'b01:   count_reg <= count_reg - CW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Pick the next bus owner from FIFO heads as they stood before this edge.
    always_comb begin
        pop        = '0;
        cdb_next   = IDLE;
        grant_next = GRANT_NONE;
        rr_next    = rr_reg;
        if (!empty[2]) begin
            pop[2]     = 1'b1;
            cdb_next   = head[2];
            grant_next = GRANT_DIR;
        end else if (!empty[0] && !empty[1]) begin
            if (!rr_reg) begin
                pop[0]     = 1'b1;
                cdb_next   = head[0];
                grant_next = GRANT_PC0;
                rr_next    = 1'b1;
            end else begin
                pop[1]     = 1'b1;
                cdb_next   = head[1];
                grant_next = GRANT_PC1;
                rr_next    = 1'b0;
            end
        end else if (!empty[0]) begin
            pop[0]     = 1'b1;
            cdb_next   = head[0];
            grant_next = GRANT_PC0;
            rr_next    = 1'b1;
        end else if (!empty[1]) begin
            pop[1]     = 1'b1;
            cdb_next   = head[1];
            grant_next = GRANT_PC1;
            rr_next    = 1'b0;
        end
    end

    // Bus, grant and round-robin registers; bus falls back to IDLE when nothing wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_reg   <= IDLE;
            grant_reg <= GRANT_NONE;
            rr_reg    <= 1'b0;
        end else begin
            cdb_reg   <= cdb_next;
            grant_reg <= grant_next;
            rr_reg    <= rr_next;
        end
    end

    // Sticky drop flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_reg <= 3'b000;
        end else begin
            overflow_reg <= overflow_reg | drop;
        end
    end

    assign cdb      = cdb_reg;
    assign grant    = grant_reg;
    assign pc0_full = full[0];
    assign pc1_full = full[1];
    assign dir_full = full[2];
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues the expected bus
// transactions with the cycle they must appear in; a negedge monitor pops
// and compares every non-idle bus value.
module tb_cdb_arbiter;

    localparam int          DEPTH = 4;
    localparam logic [21:0] IDLE  = 22'h3FFFFF;

    logic        clock;
    logic        reset;
    logic [21:0] pc0_msg;
    logic [21:0] pc1_msg;
    logic [21:0] dir_msg;
    logic [21:0] cdb;
    logic [1:0]  grant;
    logic        pc0_full;
    logic        pc1_full;
    logic        dir_full;
    logic [2:0]  overflow;

    cdb_arbiter #(.DEPTH(DEPTH), .IDLE(IDLE)) dut (
        .clock    (clock),
        .reset    (reset),
        .pc0_msg  (pc0_msg),
        .pc1_msg  (pc1_msg),
        .dir_msg  (dir_msg),
        .cdb      (cdb),
        .grant    (grant),
        .pc0_full (pc0_full),
        .pc1_full (pc1_full),
        .dir_full (dir_full),
        .overflow (overflow)
    );

    typedef struct {
        int          cyc;
        logic [21:0] msg;
        logic [1:0]  gr;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter: after edge N (and before the next one) cyc == N.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_msg(input int c, input logic [21:0] m, input logic [1:0] g);
        exp_t e;
        e.cyc = c;
        e.msg = m;
        e.gr  = g;
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs();
        pc0_msg = IDLE;
        pc1_msg = IDLE;
        dir_msg = IDLE;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every non-idle bus value must match the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            n_checks++;
            $display("FAIL sb_missing: got nothing, required msg %h grant %0d at cycle %0d",
                     sb_q[0].msg, sb_q[0].gr, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (cdb !== IDLE || grant !== 2'd0) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got msg %h grant %0d at cycle %0d, required idle bus",
                         cdb, grant, cyc);
            end else begin
                e = sb_q.pop_front();
                $display("cdb cycle %0d msg %h grant %0d", cyc, cdb, grant);
                if (e.cyc == cyc && cdb === e.msg && grant === e.gr) n_pass++;
                else $display("FAIL sb_txn: got cycle %0d msg %h grant %0d, required cycle %0d msg %h grant %0d",
                              cyc, cdb, grant, e.cyc, e.msg, e.gr);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int          n;
        logic [21:0] a [3];
        logic [21:0] b [3];

        a[0] = 22'h010100; a[1] = 22'h010200; a[2] = 22'h010300;
        b[0] = 22'h020100; b[1] = 22'h020200; b[2] = 22'h020300;

        // Reset state, then idle inputs keep the bus idle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check("idle_cdb",   cdb, IDLE);
            check("idle_grant", grant, 2'd0);
            check("idle_ovf",   overflow, 3'b000);
            check("idle_full",  {pc0_full, pc1_full, dir_full}, 3'b000);
            tick();
        end

        // Single PC0 message: visible for exactly one cycle after edge k+1.
        do_reset();
        n = cyc;
        pc0_msg = 22'h012000;
        expect_msg(n + 2, 22'h012000, 2'd1);
        tick();
        pc0_msg = IDLE;
        tick();
        tick();
        check("single_back_idle", cdb, IDLE);
        check("single_grant_0",   grant, 2'd0);
        repeat (3) tick();

        // All three sources at once: DIR first, then PC0, then PC1.
        do_reset();
        n = cyc;
        pc0_msg = 22'h012000;
        pc1_msg = 22'h013000;
        dir_msg = 22'h042000;
        expect_msg(n + 2, 22'h042000, 2'd3);
        expect_msg(n + 3, 22'h012000, 2'd1);
        expect_msg(n + 4, 22'h013000, 2'd2);
        tick();
        idle_inputs();
        repeat (5) tick();

        // Back-to-back PC traffic alternates 1,2,1,2,1,2 in per-source order.
        do_reset();
        n = cyc;
        for (int i = 0; i < 3; i++) begin
            expect_msg(n + 2 + 2 * i, a[i], 2'd1);
            expect_msg(n + 3 + 2 * i, b[i], 2'd2);
        end
        for (int i = 0; i < 3; i++) begin
            pc0_msg = a[i];
            pc1_msg = b[i];
            tick();
        end
        idle_inputs();
        repeat (7) tick();

        // PC1 overflow while DIR holds the bus: 4 queued, 2 dropped.
        do_reset();
        n = cyc;
        for (int j = 1; j <= 7; j++) expect_msg(n + j + 1, 22'h040000 + 22'(j), 2'd3);
        for (int j = 1; j <= 4; j++) expect_msg(n + 8 + j, 22'h021000 + 22'(j), 2'd2);
        for (int j = 1; j <= 12; j++) begin
            dir_msg = (j <= 7) ? 22'h040000 + 22'(j) : IDLE;
            pc1_msg = (j <= 6) ? 22'h021000 + 22'(j) : IDLE;
            tick();
            if (j == 3) check("pc1_not_full_yet", pc1_full, 1'b0);
            if (j == 4) begin
                check("pc1_full_at_depth", pc1_full, 1'b1);
                check("ovf_before_drop",   overflow, 3'b000);
                check("dir_not_full",      dir_full, 1'b0);
            end
            if (j == 5) check("ovf_pc1_set", overflow, 3'b010);
        end
        idle_inputs();
        repeat (4) tick();
        check("ovf_pc1_sticky", overflow, 3'b010);
        check("pc1_drained",    pc1_full, 1'b0);

        // Push and pop on a full PC0 FIFO in the same cycle: no overflow.
        do_reset();
        n = cyc;
        for (int j = 1; j <= 5; j++) expect_msg(n + j + 1, 22'h041000 + 22'(j), 2'd3);
        for (int j = 1; j <= 4; j++) expect_msg(n + 6 + j, 22'h011000 + 22'(j), 2'd1);
        expect_msg(n + 11, 22'h011007, 2'd1);
        for (int j = 1; j <= 12; j++) begin
            dir_msg = (j <= 5) ? 22'h041000 + 22'(j) : IDLE;
            pc0_msg = (j <= 4 || j == 7) ? 22'h011000 + 22'(j) : IDLE;
            tick();
            if (j == 4) check("pc0_full_at_depth", pc0_full, 1'b1);
            if (j == 7) begin
                check("pc0_full_pushpop", pc0_full, 1'b1);
                check("ovf_pushpop",      overflow, 3'b000);
            end
        end
        idle_inputs();
        repeat (3) tick();

        // Reset with three PC0 messages queued and a DIR message on the bus.
        do_reset();
        n = cyc;
        expect_msg(n + 2, 22'h042100, 2'd3);
        expect_msg(n + 3, 22'h042200, 2'd3);
        dir_msg = 22'h042100; pc0_msg = 22'h014001; tick();
        dir_msg = 22'h042200; pc0_msg = 22'h014002; tick();
        dir_msg = IDLE;       pc0_msg = 22'h014003; tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_cdb",   cdb, IDLE);
        check("rst_mid_grant", grant, 2'd0);
        check("rst_mid_full",  {pc0_full, pc1_full, dir_full}, 3'b000);
        check("rst_mid_ovf",   overflow, 3'b000);
        repeat (8) tick();

        check("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
